mul_div_unit: RTL and testbench

Iterative multiply/divide unit in the EX stage of the MIPS pipeline; computes MULT, MULTU, DIV, DIVU and produces the HI/LO write data and write enable consumed by the HI and LO register instances.
One operation in flight at a time, with radix-2, one bit per cycle.
Asserts a pipeline stall while computing, so the following instruction sees updated HI/LO.

---
 rtl/mul_div_unit_if.sv | 26 ++
 rtl/mul_div_unit.sv | 184 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// Issue/result bundle between the EX stage and the iterative multiply/divide unit.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             busy;
    logic             stall;
    logic             hilo_we;
    logic [WIDTH-1:0] hi_wd;
    logic [WIDTH-1:0] lo_wd;
    logic             div_by_zero;

    modport master (
        output start, op, a, b, cancel,
        input  busy, stall, hilo_we, hi_wd, lo_wd, div_by_zero
    );

    modport slave (
        input  start, op, a, b, cancel,
        output busy, stall, hilo_we, hi_wd, lo_wd, div_by_zero
    );
endinterface

// File: rtl/mul_div_unit.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU producing HI/LO write data.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input logic           clk,
    input logic           rst_n,
    mul_div_unit_if.slave bus
);
    localparam int CW = $clog2(ITER);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   opd_q, opd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               accept;
    logic               neg_a;
    logic               neg_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   dvd;
    logic               last_it;

    assign accept = (state_q == S_IDLE) & bus.start & ~bus.cancel;
    assign neg_a  = ~bus.op[0] & bus.a[WIDTH-1];
    assign neg_b  = ~bus.op[0] & bus.b[WIDTH-1];
    assign mag_a  = neg_a ? -bus.a : bus.a;
    assign mag_b  = neg_b ? -bus.b : bus.b;

    // Upper half plus multiplicand keeps its carry in bit WIDTH.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, opd_q} : {(WIDTH+1){1'b0}});

    // Partial remainder shifted left with the next dividend bit.
    assign rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
    assign diff   = rem_sh - {1'b0, opd_q};

    assign prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
    assign quo  = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0]
                                : acc_q[WIDTH-1:0];
    assign rem  = sa_q ? -acc_q[2*WIDTH-1:WIDTH]
                       : acc_q[2*WIDTH-1:WIDTH];
    assign dvd  = sa_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

    assign last_it = (cnt_q == CW'(ITER - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        dbz_d    = dbz_q;
        opd_d    = opd_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    is_div_d = bus.op[1];
                    sa_d     = neg_a;
                    sb_d     = neg_b;
                    dbz_d    = 1'b0;
                    cnt_d    = '0;
                    if (bus.op[1]) begin
                        state_d = S_DIV;
                        opd_d   = mag_b;
                        acc_d   = {{WIDTH{1'b0}}, mag_a};
                    end else begin
                        state_d = S_MUL;
                        opd_d   = mag_a;
                        acc_d   = {{WIDTH{1'b0}}, mag_b};
                    end
                end
            end
            S_MUL: begin
                if (bus.cancel) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    cnt_d = cnt_q + CW'(1);
                    if (last_it) state_d = S_FIX;
                end
            end
            S_DIV: begin
                if (bus.cancel) begin
                    state_d = S_IDLE;
                end else if (opd_q == '0) begin
                    dbz_d   = 1'b1;
                    state_d = S_FIX;
                end else begin
                    if (!diff[WIDTH]) begin
                        acc_d = {diff[WIDTH-1:0],
                                 acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {rem_sh[WIDTH-1:0],
                                 acc_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (last_it) state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (bus.cancel) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                    if (dbz_q) begin
                        hi_d = dvd;
                        lo_d = '1;
                    end else if (is_div_q) begin
                        hi_d = rem;
                        lo_d = quo;
                    end else begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            dbz_q    <= 1'b0;
            opd_q    <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            dbz_q    <= dbz_d;
            opd_q    <= opd_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign bus.busy = (state_q == S_MUL) | (state_q == S_DIV)
                    | (state_q == S_FIX);
    assign bus.stall       = bus.busy | accept;
    assign bus.hilo_we     = (state_q == S_DONE) & ~bus.cancel;
    assign bus.div_by_zero = bus.hilo_we & dbz_q;
    assign bus.hi_wd       = hi_q;
    assign bus.lo_wd       = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Random and directed checks of mul_div_unit against an arithmetic model.
module tb_mul_div_unit;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    logic [31:0] last_hi;
    logic [31:0] last_lo;

    mul_div_unit_if #(.WIDTH(32)) bus ();

    mul_div_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {dbz, hi, lo} from plain integer arithmetic.
    function automatic logic [64:0] ref_op(input logic [1:0] o,
                                           input logic [31:0] x,
                                           input logic [31:0] y);
        longint      sx, sy, q, r;
        logic [63:0] p;
        sx = longint'(signed'(x));
        sy = longint'(signed'(y));
        case (o)
            2'd0: begin
                p = 64'(sx * sy);
                return {1'b0, p};
            end
            2'd1: begin
                p = {32'd0, x} * {32'd0, y};
                return {1'b0, p};
            end
            default: begin
                if (y == 32'd0) return {1'b1, x, 32'hFFFFFFFF};
                if (o == 2'd2) begin
                    q = sx / sy;
                    r = sx % sy;
                    return {1'b0, 32'(r), 32'(q)};
                end
                return {1'b0, x % y, x / y};
            end
        endcase
    endfunction

    task automatic run_op(input logic [1:0] o,
                          input logic [31:0] x,
                          input logic [31:0] y,
                          input int cancel_at,
                          input bit cancel_done);
        logic [64:0] e;
        int          stalls;
        int          busys;
        int          we_seen;
        bit          got;
        bit          killed;
        logic [31:0] ghi;
        logic [31:0] glo;
        logic        gdbz;
        e = ref_op(o, x, y);
        stalls = 0;
        busys = 0;
        got = 0;
        killed = 0;
        ghi = '0;
        glo = '0;
        gdbz = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = o;
        bus.a = x;
        bus.b = y;
        bus.cancel = 1'b0;
        for (int i = 0; i < 80 && !got && !killed; i++) begin
            #1;
            if (bus.stall) stalls++;
            if (bus.busy) busys++;
            if (bus.hilo_we) begin
                if (cancel_done) begin
                    bus.cancel = 1'b1;
                    #1;
                    check("done_cancel_we", 64'(bus.hilo_we), 0);
                    check("done_cancel_dbz", 64'(bus.div_by_zero), 0);
                    killed = 1;
                end else begin
                    got = 1;
                    ghi = bus.hi_wd;
                    glo = bus.lo_wd;
                    gdbz = bus.div_by_zero;
                end
            end
            @(negedge clk);
            bus.cancel = 1'b0;
            bus.a = $urandom;
            bus.b = $urandom;
            bus.op = 2'($urandom);
            bus.start = (got || killed) ? 1'b0
                                        : 1'($urandom_range(0, 1));
            if (cancel_at >= 0 && busys == cancel_at && !killed) begin
                bus.cancel = 1'b1;
                bus.start = 1'b0;
                killed = 1;
            end
        end
        if (got) begin
            check("hi", 64'(ghi), 64'(e[63:32]));
            check("lo", 64'(glo), 64'(e[31:0]));
            check("dbz", 64'(gdbz), 64'(e[64]));
            check("stall_cycles", 64'(stalls), e[64] ? 3 : 34);
            check("busy_cycles", 64'(busys), e[64] ? 2 : 33);
            #1;
            check("we_pulse", 64'(bus.hilo_we), 0);
            check("busy_after", 64'(bus.busy), 0);
            last_hi = e[63:32];
            last_lo = e[31:0];
        end else if (killed && cancel_done) begin
            last_hi = e[63:32];
            last_lo = e[31:0];
            #1;
            check("done_cancel_busy", 64'(bus.busy), 0);
        end else if (killed) begin
            @(negedge clk);
            bus.cancel = 1'b0;
            #1;
            check("cancel_busy", 64'(bus.busy), 0);
            check("cancel_stall", 64'(bus.stall), 0);
            we_seen = 0;
            for (int k = 0; k < 4; k++) begin
                if (bus.hilo_we) we_seen++;
                @(negedge clk);
                #1;
            end
            check("cancel_no_we", 64'(we_seen), 0);
            check("cancel_hi_hold", 64'(bus.hi_wd), 64'(last_hi));
            check("cancel_lo_hold", 64'(bus.lo_wd), 64'(last_lo));
        end else begin
            check("timeout", 0, 1);
        end
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        n_tests = 0;
        n_fail = 0;
        last_hi = '0;
        last_lo = '0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.op = 2'd0;
        bus.a = '0;
        bus.b = '0;
        bus.cancel = 1'b0;
        #1;
        check("rst_busy", 64'(bus.busy), 0);
        check("rst_we", 64'(bus.hilo_we), 0);
        check("rst_hi", 64'(bus.hi_wd), 0);
        check("rst_lo", 64'(bus.lo_wd), 0);
        check("rst_dbz", 64'(bus.div_by_zero), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(2'd0, 32'hFFFFFFFD, 32'd5, -1, 0);
        run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 0);
        run_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 0);
        run_op(2'd2, 32'hFFFFFFF9, 32'd2, -1, 0);
        run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, -1, 0);
        run_op(2'd3, 32'd100, 32'd0, -1, 0);
        run_op(2'd2, 32'hFFFFFF9C, 32'd0, -1, 0);
        run_op(2'd3, 32'd100, 32'd7, 10, 0);
        run_op(2'd3, 32'd100, 32'd7, -1, 0);
        run_op(2'd0, 32'd1234, 32'hFFFF0000, -1, 1);

        // cancel alongside start in IDLE must not launch
        @(negedge clk);
        bus.start = 1'b1;
        bus.cancel = 1'b1;
        #1;
        check("idle_cancel_stall", 64'(bus.stall), 0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.cancel = 1'b0;
        #1;
        check("idle_cancel_busy", 64'(bus.busy), 0);

        // asynchronous reset in the middle of a multiply
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = 2'd1;
        bus.a = 32'hDEADBEEF;
        bus.b = 32'h12345678;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(bus.busy), 0);
        check("mid_rst_stall", 64'(bus.stall), 0);
        check("mid_rst_we", 64'(bus.hilo_we), 0);
        check("mid_rst_hi", 64'(bus.hi_wd), 0);
        check("mid_rst_lo", 64'(bus.lo_wd), 0);
        last_hi = '0;
        last_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 30; n++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: ra = 32'h80000000;
                3: rb = 32'($urandom_range(1, 20));
                default: ;
            endcase
            run_op(ro, ra, rb, -1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
